// File: rtl/spectro_pkg.sv
// Shared definitions for the spectrogram capture core.
//   state_t       : capture FSM states (IDLE, CAPTURE, READOUT)
//   DEF_*         : default geometry, with derived address width and post-trigger length
//   post_len      : post-trigger window length for a given depth / pre-trigger size
//   popcount_sat  : counts set bits in the low 'width' bits and saturates at max_level
package spectro_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2
    } state_t;

    localparam int DEF_DEPTH   = 256;
    localparam int DEF_PRETRIG = 16;
    localparam int AW          = $clog2(DEF_DEPTH);
    localparam int POST        = DEF_DEPTH - DEF_PRETRIG;

    function automatic int post_len(input int depth, input int pretrig);
        return depth - pretrig;
    endfunction

    // Bubbles in the thermometer code are counted rather than corrected,
    // so a broken comparator reads as a lower level, never as a glitch to full scale.
    function automatic int unsigned popcount_sat(input logic [63:0] bits,
                                                 input int unsigned width,
                                                 input int unsigned max_level);
        int unsigned cnt;
        cnt = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd64; i++) begin
            if (i < width) begin
                cnt = cnt + {31'd0, bits[i]};
            end else begin
                cnt = cnt;
            end
        end
        if (cnt > max_level) begin
            return max_level;
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/thermo_encoder.sv
// Thermometer-to-binary level encoder for one band channel.
//   therm : THERM_W comparator outputs, bit 0 = lowest threshold
//   level : number of set bits, saturated to 2^ENC_W-1
module thermo_encoder
    import spectro_pkg::*;
#(
    parameter int THERM_W = 7,
    parameter int ENC_W   = 3
) (
    input  logic [THERM_W-1:0] therm,
    output logic [ENC_W-1:0]   level
);

    localparam int unsigned MAX_LEVEL = (32'd1 << ENC_W) - 32'd1;

    // Combinational popcount feeding the frame buffer write port.
    always_comb begin
        level = ENC_W'(popcount_sat(64'(therm), 32'(THERM_W), MAX_LEVEL));
    end

endmodule

// File: rtl/spectrogram_capture_core.sv
// Spectrogram capture core: encodes N_CH thermometer channels, keeps a circular
// pre-trigger history, captures a post-trigger window on detection and streams
// the frame oldest-first over a valid/ready interface.
//   clk, reset (sync, active-high)
//   sample_en, ch_therm, event_time : acquisition inputs
//   out_ready / out_valid, out_data, out_last : frame stream
//   evt_time : timestamp latched at trigger
//   busy : CAPTURE or READOUT; missed_cnt : saturating count of triggers lost while busy
module spectrogram_capture_core
    import spectro_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int THERM_W = 7,
    parameter int ENC_W   = 3,
    parameter int DEPTH   = 256,
    parameter int PRETRIG = 16,
    parameter int TS_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic [N_CH*THERM_W-1:0]  ch_therm,
    input  logic [TS_W-1:0]          event_time,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [N_CH*ENC_W-1:0]    out_data,
    output logic                     out_last,
    output logic [TS_W-1:0]          evt_time,
    output logic                     busy,
    output logic [7:0]               missed_cnt
);

    localparam int LAW  = $clog2(DEPTH);
    localparam int LPST = post_len(DEPTH, PRETRIG);
    localparam int DW   = N_CH * ENC_W;
    localparam logic [LAW:0]   PRE_L     = (LAW+1)'(PRETRIG);
    localparam logic [LAW:0]   POST_L    = (LAW+1)'(LPST);
    localparam logic [LAW:0]   POST_M1_L = (LAW+1)'(LPST - 1);
    localparam logic [LAW:0]   ONE_C     = (LAW+1)'(1);
    localparam logic [LAW-1:0] ONE_A     = LAW'(1);

    logic [DW-1:0]   enc_word_s;
    logic [N_CH-1:0] ch_bit0_s;
    logic            trig_s;
    logic            we_s;
    logic            pop_s;
    logic            rd_issue_s;
    logic [1:0]      occ_s;
    logic [LAW-1:0]  rd_addr_s;

    state_t          state_r;
    logic [LAW-1:0]  wp_r;
    logic [LAW:0]    pre_cnt_r;
    logic [LAW:0]    post_cnt_r;
    logic [LAW-1:0]  start_r;
    logic [LAW:0]    len_r;
    logic [LAW:0]    rd_cnt_r;
    logic            rd_pend_r;
    logic            rd_last_r;
    logic [DW-1:0]   rd_data_r;
    logic            out_valid_r;
    logic [DW-1:0]   out_data_r;
    logic            out_last_r;
    logic            skid_valid_r;
    logic [DW-1:0]   skid_data_r;
    logic            skid_last_r;
    logic [TS_W-1:0] evt_time_r;
    logic            busy_r;
    logic [7:0]      missed_cnt_r;
    logic [DW-1:0]   mem_r [DEPTH];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        thermo_encoder #(
            .THERM_W (THERM_W),
            .ENC_W   (ENC_W)
        ) u_enc (
            .therm (ch_therm[c*THERM_W +: THERM_W]),
            .level (enc_word_s[c*ENC_W +: ENC_W])
        );
        assign ch_bit0_s[c] = ch_therm[c*THERM_W];
    end

    // Trigger, write enable and read-issue decisions.
    always_comb begin
        trig_s    = sample_en & (|ch_bit0_s);
        we_s      = sample_en & (state_r != READOUT);
        pop_s     = out_valid_r & out_ready;
        rd_addr_s = start_r + rd_cnt_r[LAW-1:0];
        // Words held in output reg, skid reg or in flight from the RAM; never more than two,
        // so the in-flight word always has somewhere to land even when out_ready drops.
        occ_s     = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, rd_pend_r};
        if ((state_r == READOUT) && (rd_cnt_r < len_r)) begin
            rd_issue_s = ((occ_s - {1'b0, pop_s}) < 2'd2);
        end else begin
            rd_issue_s = 1'b0;
        end
    end

    // Frame buffer: encoder write port and registered read port.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wp_r] <= enc_word_s;
        end
        rd_data_r <= mem_r[rd_addr_s];
    end

    // Capture FSM, readout pipeline and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            wp_r         <= '0;
            pre_cnt_r    <= '0;
            post_cnt_r   <= '0;
            start_r      <= '0;
            len_r        <= '0;
            rd_cnt_r     <= '0;
            rd_pend_r    <= 1'b0;
            rd_last_r    <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_last_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
            skid_last_r  <= 1'b0;
            evt_time_r   <= '0;
            busy_r       <= 1'b0;
            missed_cnt_r <= 8'd0;
        end else begin
            if (trig_s && (state_r != IDLE) && (missed_cnt_r != 8'd255)) begin
                missed_cnt_r <= missed_cnt_r + 8'd1;
            end
            case (state_r)
                IDLE: begin
                    if (sample_en) begin
                        wp_r <= wp_r + ONE_A;
                        if (trig_s) begin
                            // The trigger sample itself is post-sample 0.
                            evt_time_r <= event_time;
                            start_r    <= wp_r - pre_cnt_r[LAW-1:0];
                            len_r      <= pre_cnt_r + POST_L;
                            post_cnt_r <= ONE_C;
                            rd_cnt_r   <= '0;
                            busy_r     <= 1'b1;
                            state_r    <= (POST_L == ONE_C) ? READOUT : CAPTURE;
                        end else if (pre_cnt_r < PRE_L) begin
                            pre_cnt_r <= pre_cnt_r + ONE_C;
                        end
                    end
                end
                CAPTURE: begin
                    if (sample_en) begin
                        wp_r       <= wp_r + ONE_A;
                        post_cnt_r <= post_cnt_r + ONE_C;
                        if (post_cnt_r == POST_M1_L) begin
                            state_r <= READOUT;
                        end
                    end
                end
                READOUT: begin
                    rd_pend_r <= rd_issue_s;
                    if (rd_issue_s) begin
                        rd_cnt_r  <= rd_cnt_r + ONE_C;
                        rd_last_r <= (rd_cnt_r == (len_r - ONE_C));
                    end
                    if (pop_s || !out_valid_r) begin
                        if (skid_valid_r) begin
                            out_valid_r  <= 1'b1;
                            out_data_r   <= skid_data_r;
                            out_last_r   <= skid_last_r;
                            skid_valid_r <= rd_pend_r;
                            skid_data_r  <= rd_data_r;
                            skid_last_r  <= rd_last_r;
                        end else if (rd_pend_r) begin
                            out_valid_r <= 1'b1;
                            out_data_r  <= rd_data_r;
                            out_last_r  <= rd_last_r;
                        end else begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                        end
                    end else if (rd_pend_r) begin
                        // Output is stalled: park the arriving word in the skid slot.
                        skid_valid_r <= 1'b1;
                        skid_data_r  <= rd_data_r;
                        skid_last_r  <= rd_last_r;
                    end
                    if (pop_s && out_last_r) begin
                        state_r   <= IDLE;
                        busy_r    <= 1'b0;
                        pre_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign evt_time   = evt_time_r;
    assign busy       = busy_r;
    assign missed_cnt = missed_cnt_r;

endmodule
